uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive controller that consumes the start-edge pulse `H2L_Sig` from the UART RX falling-edge detector.
- Times mid-bit sample points with an internal baud counter, validates the start bit, shifts in 8 data bits LSB first and checks the stop bit.
- Presents the received byte with a one-cycle done pulse to the downstream consumer (FIFO or user logic).
- Frame format is fixed 8N1.

Parameters:
- BAUD_DIV, 5208, CLOCK cycles per bit (50 MHz / 9600 baud); legal range >= 4.
- HALF_DIV, BAUD_DIV/2, cycles from start-edge pulse to start-bit sample point.

Ports:
- CLOCK  input  1  system clock
- RST_n  input  1  asynchronous active-low reset
- RXD  input  1  raw serial line, idle high
- H2L_Sig  input  1  one-cycle falling-edge pulse from the edge detector
- RX_En_Sig  input  1  receive enable; low holds the block idle / aborts a frame
- RX_Data  output  8  last correctly received byte
- RX_Done_Sig  output  1  one-cycle pulse, RX_Data valid and updated
- Frame_Err  output  1  one-cycle pulse, stop bit sampled low
- RX_Busy  output  1  high while state != IDLE

Behaviour:
- Reset is RST_n (asynchronous, active-low); clock is CLOCK.
- Reset values: RX_Data=8'h00, RX_Done_Sig=0, Frame_Err=0, RX_Busy=0.
  - Internal 2-flop RXD synchroniser resets to 1.
  - State resets to IDLE; baud and bit counters reset to 0.
- RXD is sampled only through the internal 2-flop synchroniser (rxd_s).
- Baud counter: width ceil(log2(BAUD_DIV)).
  - Increments every cycle outside IDLE/DONE.
  - Clears to 0 on each sample and on state entry.
- State IDLE:
  - H2L_Sig=1 and RX_En_Sig=1 -> START, counters cleared.
  - H2L_Sig is ignored in every other state.
- State START:
  - When baud counter reaches HALF_DIV-1, sample rxd_s.
  - rxd_s=0 -> DATA, counter cleared.
  - rxd_s=1 -> false start (glitch); return to IDLE with no output pulse.
- State DATA:
  - Each time the counter reaches BAUD_DIV-1, sample rxd_s into shift register bit[bit_cnt], with bit_cnt running 0..7 (LSB first).
  - After bit_cnt=7 is sampled -> STOP.
- State STOP:
  - At counter BAUD_DIV-1, sample rxd_s.
  - rxd_s=1: RX_Data <= shift register; go to DONE.
  - rxd_s=0: Frame_Err=1 for the next cycle; RX_Data unchanged; go to IDLE.
- State DONE: RX_Done_Sig=1 for exactly this one cycle, then IDLE.
  - RX_Done_Sig and the RX_Data update become visible on the same clock edge.
- Sample spacing: every data and stop sample falls exactly BAUD_DIV cycles after the previous sample.
- RX_Done_Sig rises HALF_DIV + 9*BAUD_DIV + 1 cycles after the H2L_Sig cycle.
- RX_Data holds its value until the next good frame; Frame_Err and false starts never modify it.
- Done timing: the block reaches IDLE mid-stop-bit, so a back-to-back start edge is caught.
- Abort: RX_En_Sig low in any non-IDLE state forces IDLE on the next clock.
  - No done or error pulse; RX_Data unchanged.
- Collision rule: RX_Done_Sig and Frame_Err are never high in the same cycle.
- Reset asserted mid-frame returns all outputs to reset values immediately; no pulse is generated after release.

Test Plan:
- BAUD_DIV=16, RX_En_Sig=1, send 8'h55 with stop=1 via the detector.
  - RX_Data=8'h55 and RX_Done_Sig high exactly 1 cycle, 8+144+1 cycles after H2L_Sig.
  - RX_Busy falls 1 cycle after Done.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap (next start edge right after stop bit).
  - Two Done pulses, with RX_Data 8'h00 then 8'hFF.
- RXD low glitch of 3 cycles.
  - H2L_Sig fires, start sample at cycle 8 reads 1, back to IDLE.
  - No Done, no Frame_Err, RX_Data unchanged.
- Send 8'hA3 with stop bit driven 0, after a prior good 8'h55.
  - Frame_Err 1-cycle pulse, RX_Done_Sig stays 0, RX_Data remains 8'h55.
- Drop RX_En_Sig during data bit 4 of 8'h3C.
  - IDLE next cycle, RX_Busy=0, no pulses.
  - A following 8'hC3 frame with enable high is received correctly.
- Assert RST_n=0 mid-data-bit 5.
  - All outputs return to reset values asynchronously.
  - After release, the remainder of the interrupted frame produces no Done; the next full frame 8'h81 is received.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive controller for a fixed 8N1 UART frame. A start is announced by a
// one-cycle pulse on H2L_Sig from an external falling-edge detector. The block
// checks the start bit at mid-bit and then samples each data bit and the stop
// bit one bit-time apart. A good byte is presented on RX_Data together with a
// one-cycle RX_Done_Sig pulse.
//
// State table:
//   IDLE  | waiting for a start-edge pulse
//   START | counting to the middle of the start bit, then checking that it is low
//   DATA  | sampling 8 data bits LSB first, one bit-time apart
//   STOP  | sampling the stop bit; high = good frame, low = framing error
//   DONE  | one-cycle RX_Done_Sig pulse, then back to IDLE
//
// Ports:
//   CLOCK       in   system clock
//   RST_n       in   asynchronous active-low reset
//   RXD         in   raw serial line, idle high (synchronised internally)
//   H2L_Sig     in   one-cycle start-edge pulse
//   RX_En_Sig   in   receive enable; low forces IDLE
//   RX_Data     out  last correctly received byte
//   RX_Done_Sig out  one-cycle pulse, RX_Data valid and updated
//   Frame_Err   out  one-cycle pulse, stop bit sampled low
//   RX_Busy     out  high while not IDLE
module uart_rx_ctrl #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       RXD,
  input  logic       H2L_Sig,
  input  logic       RX_En_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Done_Sig,
  output logic       Frame_Err,
  output logic       RX_Busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rxd_m;
  logic          rxd_s;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rxd_m       <= 1'b1;
      rxd_s       <= 1'b1;
      RX_Data     <= 8'h00;
      RX_Done_Sig <= 1'b0;
      Frame_Err   <= 1'b0;
      RX_Busy     <= 1'b0;
    end else begin
      rxd_m       <= RXD;
      rxd_s       <= rxd_m;
      // Both status outputs are single-cycle pulses by default.
      RX_Done_Sig <= 1'b0;
      Frame_Err   <= 1'b0;

      if (state != IDLE && !RX_En_Sig) begin
        // Abort: drop the frame silently, RX_Data untouched.
        state    <= IDLE;
        RX_Busy  <= 1'b0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (H2L_Sig && RX_En_Sig) begin
              state    <= START;
              RX_Busy  <= 1'b1;
              baud_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
          START: begin
            if (baud_cnt == HALF_LAST) begin
              baud_cnt <= '0;
              if (!rxd_s) begin
                state <= DATA;
              end else begin
                // Line back high at mid-start: treat as a glitch.
                state   <= IDLE;
                RX_Busy <= 1'b0;
              end
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
          DATA: begin
            if (baud_cnt == BAUD_LAST) begin
              baud_cnt       <= '0;
              shreg[bit_cnt] <= rxd_s;
              bit_cnt        <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
          STOP: begin
            if (baud_cnt == BAUD_LAST) begin
              baud_cnt <= '0;
              if (rxd_s) begin
                // Data and done pulse land on the same edge.
                RX_Data     <= shreg;
                RX_Done_Sig <= 1'b1;
                state       <= DONE;
              end else begin
                Frame_Err <= 1'b1;
                state     <= IDLE;
                RX_Busy   <= 1'b0;
              end
            end else begin
              baud_cnt <= baud_cnt + CNT_ONE;
            end
          end
          DONE: begin
            // Leaving here mid-stop-bit lets a back-to-back start edge be seen.
            state   <= IDLE;
            RX_Busy <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            RX_Busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
  localparam int BD  = 16;
  localparam int HD  = BD / 2;
  localparam int LAT = HD + 9 * BD + 1;   // H2L_Sig cycle to RX_Done_Sig
  localparam int FRM = 10 * BD;           // full frame length in cycles

  logic       CLOCK = 1'b0;
  logic       RST_n = 1'b0;
  logic       RXD = 1'b1;
  logic       H2L_Sig = 1'b0;
  logic       RX_En_Sig = 1'b1;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       Frame_Err;
  logic       RX_Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int h2l_cyc = 0;
  bit prev_done = 1'b0;

  uart_rx_ctrl #(.BAUD_DIV(BD), .HALF_DIV(HD)) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .RXD        (RXD),
    .H2L_Sig    (H2L_Sig),
    .RX_En_Sig  (RX_En_Sig),
    .RX_Data    (RX_Data),
    .RX_Done_Sig(RX_Done_Sig),
    .Frame_Err  (Frame_Err),
    .RX_Busy    (RX_Busy)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLOCK) begin
    if (RX_Done_Sig || Frame_Err) chk("collision", 32'(RX_Done_Sig & Frame_Err), 32'd0);
    if (prev_done) begin
      chk("done_width", 32'(RX_Done_Sig), 32'd0);
      chk("busy_fall", 32'(RX_Busy), 32'd0);
    end
    if (RX_Done_Sig) begin
      chk("busy_at_done", 32'(RX_Busy), 32'd1);
      done_cnt++;
      done_cyc = cyc;
    end
    if (Frame_Err) err_cnt++;
    prev_done = RX_Done_Sig;
  end

  // Drives a frame (start, 8 data LSB first, stop) starting at a negedge,
  // pulsing H2L_Sig in the first cycle; stops after ncyc cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ncyc);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    h2l_cyc = cyc;
    for (int i = 0; i < ncyc; i++) begin
      RXD = bits[i / BD];
      H2L_Sig = (i == 0);
      @(negedge CLOCK);
    end
    H2L_Sig = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0;
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h55, 1'b1, 8'h55, 1, 0};
    vecs[4] = '{8'hA3, 1'b0, 8'h55, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

    repeat (3) @(negedge CLOCK);
    chk("rst_data", 32'(RX_Data), 32'h00);
    chk("rst_busy", 32'(RX_Busy), 32'd0);
    RST_n = 1'b1;
    repeat (4) @(negedge CLOCK);
    chk("idle_busy", 32'(RX_Busy), 32'd0);
    chk("idle_done", 32'(RX_Done_Sig), 32'd0);

    // Back-to-back frames, no idle gap between stop bit and next start.
    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].data, vecs[v].stop, FRM);
      chk($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'(vecs[v].exp_done));
      chk($sformatf("v%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d_data", v), 32'(RX_Data), 32'(vecs[v].exp_data));
      if (vecs[v].exp_done != 0)
        chk($sformatf("v%0d_latency", v), 32'(done_cyc - h2l_cyc), 32'(LAT));
    end
    RXD = 1'b1;
    repeat (10) @(negedge CLOCK);

    // False start: 3-cycle low glitch.
    d0 = done_cnt;
    e0 = err_cnt;
    RXD = 1'b0;
    H2L_Sig = 1'b1;
    @(negedge CLOCK);
    H2L_Sig = 1'b0;
    repeat (2) @(negedge CLOCK);
    RXD = 1'b1;
    chk("glitch_busy_start", 32'(RX_Busy), 32'd1);
    repeat (30) @(negedge CLOCK);
    chk("glitch_busy", 32'(RX_Busy), 32'd0);
    chk("glitch_done", 32'(done_cnt - d0), 32'd0);
    chk("glitch_err", 32'(err_cnt - e0), 32'd0);
    chk("glitch_data", 32'(RX_Data), 32'h81);

    // Abort in the middle of data bit 4.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b1, 5 * BD + BD / 2);
    chk("abort_busy_before", 32'(RX_Busy), 32'd1);
    RX_En_Sig = 1'b0;
    RXD = 1'b1;
    @(negedge CLOCK);
    chk("abort_busy", 32'(RX_Busy), 32'd0);
    repeat (3) @(negedge CLOCK);
    RX_En_Sig = 1'b1;
    repeat (200) @(negedge CLOCK);
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_err", 32'(err_cnt - e0), 32'd0);
    chk("abort_data", 32'(RX_Data), 32'h81);
    send_frame(8'hC3, 1'b1, FRM);
    chk("after_abort_done", 32'(done_cnt - d0), 32'd1);
    chk("after_abort_data", 32'(RX_Data), 32'hC3);
    chk("after_abort_latency", 32'(done_cyc - h2l_cyc), 32'(LAT));
    RXD = 1'b1;
    repeat (5) @(negedge CLOCK);

    // Asynchronous reset in the middle of data bit 5 of 8'hE7 (bits 5..7 and
    // stop are high, so the remainder of the frame has no falling edge).
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'hE7, 1'b1, 6 * BD + BD / 2);
    #3;
    RST_n = 1'b0;
    #1;
    chk("mrst_data", 32'(RX_Data), 32'h00);
    chk("mrst_busy", 32'(RX_Busy), 32'd0);
    chk("mrst_done", 32'(RX_Done_Sig), 32'd0);
    chk("mrst_err", 32'(Frame_Err), 32'd0);
    repeat (2) @(negedge CLOCK);
    RST_n = 1'b1;
    RXD = 1'b1;
    repeat (4 * BD) @(negedge CLOCK);
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mrst_no_err", 32'(err_cnt - e0), 32'd0);
    chk("mrst_busy_after", 32'(RX_Busy), 32'd0);
    send_frame(8'h81, 1'b1, FRM);
    chk("mrst_next_done", 32'(done_cnt - d0), 32'd1);
    chk("mrst_next_data", 32'(RX_Data), 32'h81);
    chk("mrst_next_latency", 32'(done_cyc - h2l_cyc), 32'(LAT));
    RXD = 1'b1;
    repeat (5) @(negedge CLOCK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
